fifo_uart_tx: RTL and testbench

// - Read-side consumer of the 16x8 synchronous FIFO: pops bytes via fifo_re/fifo_dout/fifo_empty.
// - Serializes each byte as an 8-N-1 UART frame (start, 8 data LSB first, stop) on tx.
// - Sits between the FIFO read port and the chip-level serial pin; sole reader of that FIFO.

---
 rtl/fifo_uart_pkg.sv | 30 +++
 rtl/fifo_uart_tx_timer.sv | 43 ++++
 rtl/fifo_uart_tx.sv | 210 +++++++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
// ---------------------------------------------------------------------------
// fifo_uart_pkg
// Shared types and constants for the FIFO-fed UART transmitter.
//   state_t  : transmitter FSM states, in frame order
//   DATA_W   : width of one FIFO entry / one UART character
//   TX_IDLE  : level driven on the serial line between frames
// ---------------------------------------------------------------------------
package fifo_uart_pkg;

    localparam int   DATA_W  = 8;
    localparam logic TX_IDLE = 1'b1;

    // IDLE   : waiting for en and a non-empty FIFO
    // FETCH  : read-enable pulse is out, FIFO presents data on the next edge
    // LOAD   : capture fifo_dout, drive the start bit
    // START  : start bit on the line
    // DATA   : eight data bits, LSB first
    // PARITY : optional parity bit
    // STOP   : stop bit, done pulses at its end
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

endpackage

// File: rtl/fifo_uart_tx_timer.sv
// ---------------------------------------------------------------------------
// uart_bit_timer
// Free-running bit-period counter for the UART transmitter. Counts
// 0..CLKS_PER_BIT-1 while clr is low and wraps on its own terminal count,
// so consecutive bits of a frame are back-to-back with no dead cycle.
//
// Ports
//   clk    in  1  rising-edge clock
//   rst_n  in  1  asynchronous active-low reset
//   clr    in  1  hold the counter at zero (used while no bit is on the line)
//   tick   out 1  high during the last cycle of each bit period
// ---------------------------------------------------------------------------
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // A cleared counter never reports terminal count, so the FSM cannot
    // advance a bit while it is still loading.
    assign tick = !clr && (cnt == TERMINAL);

    // NOTE: state lives in always_ff with non-blocking assignments only, so
    // every register samples pre-edge values no matter how blocks are ordered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx
// Sole reader of a 16x8 synchronous FIFO. Pops one byte at a time and sends
// it as an 8-N-1 UART frame (start, 8 data bits LSB first, stop) on tx.
//
// Build option
//   FIFO_UART_TX_PARITY_EN : when defined, a parity bit is inserted between
//                            the last data bit and the stop bit (11-bit frame).
//                            PARITY_ODD selects odd (1) or even (0) parity.
//                            When undefined the frame is 10 bits.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per UART bit (>= 2)
//   PARITY_ODD    0 = even parity, 1 = odd parity
//
// Ports
//   clk         in   1  rising-edge clock
//   rst_n       in   1  asynchronous active-low reset
//   en          in   1  allows a new frame to start; sampled in IDLE only
//   fifo_empty  in   1  FIFO empty flag
//   fifo_dout   in   8  FIFO registered read data, valid the cycle after re
//   fifo_re     out  1  FIFO read enable, one-cycle pulse per byte
//   tx          out  1  serial line, idle high
//   busy        out  1  high whenever a frame is being fetched or sent
//   done        out  1  one-cycle pulse at the end of each stop bit
// ---------------------------------------------------------------------------
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_re,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    // Frame sequencing
    state_t            state;
    state_t            state_nxt;
    logic [2:0]        bit_idx;       // data bit currently on the line
    logic [2:0]        bit_idx_nxt;
    logic [DATA_W-1:0] shift_reg;     // shift_reg[0] is always the next bit to send
    logic [DATA_W-1:0] shift_nxt;

    // Registered outputs and their next values
    logic              tx_nxt;
    logic              fifo_re_nxt;
    logic              done_nxt;

    // Bit timing
    logic              tick;
    logic              timer_clr;

`ifdef FIFO_UART_TX_PARITY_EN
    // Running parity of the bits already sent; seeded with PARITY_ODD so the
    // final value is the bit to transmit for either sense.
    logic              parity;
    logic              parity_nxt;
`else
    // Without the parity stage PARITY_ODD has no effect on the frame.
    localparam bit parity_odd_unused = PARITY_ODD;
`endif

    // The bit timer only runs while a bit is on the line.
    assign timer_clr = (state == IDLE) || (state == FETCH) || (state == LOAD);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (timer_clr),
        .tick  (tick)
    );

    // -----------------------------------------------------------------------
    // State register (FSM state plus all datapath and output registers)
    // -----------------------------------------------------------------------
    // NOTE: the asynchronous reset forces tx high immediately, so a frame cut
    // short by reset never leaves the line low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx        <= TX_IDLE;
            fifo_re   <= 1'b0;
            done      <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity    <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            bit_idx   <= bit_idx_nxt;
            shift_reg <= shift_nxt;
            tx        <= tx_nxt;
            fifo_re   <= fifo_re_nxt;
            done      <= done_nxt;
`ifdef FIFO_UART_TX_PARITY_EN
            parity    <= parity_nxt;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every combinational output gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (en && !fifo_empty) state_nxt = FETCH;
            FETCH:   state_nxt = LOAD;
            LOAD:    state_nxt = START;
            START:   if (tick) state_nxt = DATA;
            DATA: begin
                if (tick && (bit_idx == 3'd7)) begin
`ifdef FIFO_UART_TX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
            PARITY:  if (tick) state_nxt = STOP;
            STOP:    if (tick) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output / datapath logic
    // -----------------------------------------------------------------------
    // Each branch sets the level for the *next* bit period at the tick that
    // ends the current one, so tx changes exactly on bit boundaries.
    always_comb begin
        busy        = (state != IDLE);
        tx_nxt      = tx;
        fifo_re_nxt = 1'b0;
        done_nxt    = 1'b0;
        shift_nxt   = shift_reg;
        bit_idx_nxt = bit_idx;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_nxt  = parity;
`endif
        unique case (state)
            IDLE: begin
                tx_nxt      = TX_IDLE;
                fifo_re_nxt = en && !fifo_empty;
            end
            FETCH: begin
                // fifo_re drops by default; the FIFO updates fifo_dout on
                // this edge, so the capture happens one state later.
            end
            LOAD: begin
                shift_nxt   = fifo_dout;
                tx_nxt      = 1'b0;
                bit_idx_nxt = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                parity_nxt  = PARITY_ODD;
`endif
            end
            START: begin
                if (tick) begin
                    tx_nxt    = shift_reg[0];
                    shift_nxt = shift_reg >> 1;
`ifdef FIFO_UART_TX_PARITY_EN
                    parity_nxt = parity ^ shift_reg[0];
`endif
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        tx_nxt = parity;
`else
                        tx_nxt = TX_IDLE;
`endif
                    end else begin
                        tx_nxt      = shift_reg[0];
                        shift_nxt   = shift_reg >> 1;
                        bit_idx_nxt = bit_idx + 3'd1;
`ifdef FIFO_UART_TX_PARITY_EN
                        parity_nxt  = parity ^ shift_reg[0];
`endif
                    end
                end
            end
            PARITY: begin
                if (tick) tx_nxt = TX_IDLE;
            end
            STOP: begin
                if (tick) done_nxt = 1'b1;
            end
            default: begin
                tx_nxt = TX_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_fifo_uart_tx
// Bench for fifo_uart_tx with CLKS_PER_BIT=4. Models the 16x8 FIFO (write
// port driven by the bench, registered read data), keeps a queue of bytes
// written to the FIFO with their hand-entered even-parity bit, and a monitor
// that decodes every frame on tx sample by sample against that queue.
// ---------------------------------------------------------------------------
module tb_fifo_uart_tx;

    localparam int CPB  = 4;
    localparam bit PODD = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CLK = NBITS * CPB;   // 40 clk, or 44 with parity
    localparam int BUDGET    = 600;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       en         = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_dout  = 8'h00;
    logic       fifo_re;
    logic       tx;
    logic       busy;
    logic       done;

    logic       wr_en   = 1'b0;
    logic [7:0] wr_data = 8'h00;

    fifo_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .PARITY_ODD  (PODD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_re    (fifo_re),
        .tx         (tx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // ---------------- 16x8 synchronous FIFO model ----------------
    logic [7:0] fifo_q[$];
    int         re_pulses   = 0;
    int         re_on_empty = 0;

    initial forever begin
        @(posedge clk);
        if (fifo_re === 1'b1) begin
            re_pulses++;
            if (fifo_q.size() == 0) re_on_empty++;
            else fifo_dout <= fifo_q.pop_front();
        end
        if (wr_en && fifo_q.size() < 16) fifo_q.push_back(wr_data);
        fifo_empty <= (fifo_q.size() == 0);
    end

    // ---------------- scoreboard and line monitor ----------------
    logic [8:0]  exp_q[$];          // {even parity, data}
    logic [10:0] mon_exp     = '1;
    bit          mon_active  = 1'b0;
    bit          len_run     = 1'b0;
    int          mon_idx     = 0;
    int          mon_bad     = 0;
    int          frames      = 0;
    int          done_pulses = 0;
    int          high_run    = 0;
    int          last_gap    = 0;
    int          len_cnt     = 0;
    int          last_len    = 0;

    function automatic logic [10:0] frame_of(input logic [8:0] e);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = e[7:0];
`ifdef FIFO_UART_TX_PARITY_EN
        f[9]   = e[8] ^ PODD;
`endif
        return f;
    endfunction

    initial forever begin
        @(negedge clk);
        if (rst_n !== 1'b1) begin
            mon_active = 1'b0;
            len_run    = 1'b0;
            high_run   = 0;
        end else begin
            if (done === 1'b1) done_pulses++;
            if (len_run) begin
                len_cnt++;
                if (done === 1'b1) begin
                    last_len = len_cnt;
                    len_run  = 1'b0;
                end
            end
            if (!mon_active && tx === 1'b0) begin
                last_gap   = high_run;
                high_run   = 0;
                len_cnt    = 0;
                len_run    = 1'b1;
                mon_active = 1'b1;
                mon_idx    = 0;
                mon_bad    = 0;
                check("frame_pending", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) mon_exp = frame_of(exp_q.pop_front());
                else mon_exp = '1;
            end else if (!mon_active) begin
                high_run++;
            end
            if (mon_active) begin
                if (tx !== mon_exp[mon_idx / CPB]) mon_bad++;
                mon_idx++;
                if (mon_idx == FRAME_CLK) begin
                    mon_active = 1'b0;
                    high_run   = 0;
                    frames++;
                    check("frame_bits", mon_bad, 0);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_byte(input logic [7:0] b, input logic par_even);
        wr_en   = 1'b1;
        wr_data = b;
        exp_q.push_back({par_even, b});
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((fifo_q.size() != 0 || busy !== 1'b0 || mon_active) && k < BUDGET) begin
            @(negedge clk);
            k++;
        end
        check_bit({name, "_timeout"}, k < BUDGET, 1'b1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_re(input string name);
        int k;
        k = 0;
        while (fifo_re !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check_bit({name, "_re_timeout"}, k < 20, 1'b1);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par_even;
        int         exp_pulses;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int re0;
        int done0;
        int frames0;
        int k;

        vecs[0] = '{8'hA5, 1'b0, 1};
        vecs[1] = '{8'h00, 1'b0, 1};
        vecs[2] = '{8'hFF, 1'b0, 1};
        vecs[3] = '{8'h3C, 1'b0, 1};
        vecs[4] = '{8'h07, 1'b1, 1};
        vecs[5] = '{8'h80, 1'b1, 1};

        // Reset state, then stay idle with an empty FIFO and en=1.
        en = 1'b1;
        repeat (3) @(negedge clk);
        check_bit("rst_tx",      tx,      1'b1);
        check_bit("rst_fifo_re", fifo_re, 1'b0);
        check_bit("rst_busy",    busy,    1'b0);
        check_bit("rst_done",    done,    1'b0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("empty_idle_re", re_pulses, 0);
        check_bit("empty_idle_tx",   tx,   1'b1);
        check_bit("empty_idle_busy", busy, 1'b0);

        // Single byte: start bit follows the read pulse by two cycles.
        re0   = re_pulses;
        done0 = done_pulses;
        push_byte(8'hA5, 1'b0);
        wait_re("lat");
        k = 0;
        while (tx !== 1'b0 && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("re_to_tx_low", k, 2);
        wait_idle("lat");
        check("lat_re_count",   re_pulses - re0,     1);
        check("lat_done_count", done_pulses - done0, 1);
        check_bit("lat_busy_after", busy, 1'b0);

        // Table of single-byte frames.
        foreach (vecs[i]) begin
            re0     = re_pulses;
            done0   = done_pulses;
            frames0 = frames;
            push_byte(vecs[i].data, vecs[i].par_even);
            wait_idle($sformatf("vec%0d", i));
            check($sformatf("vec%0d_re", i),     re_pulses - re0,     vecs[i].exp_pulses);
            check($sformatf("vec%0d_done", i),   done_pulses - done0, vecs[i].exp_pulses);
            check($sformatf("vec%0d_frames", i), frames - frames0,    vecs[i].exp_pulses);
            check($sformatf("vec%0d_len", i),    last_len,            FRAME_CLK);
        end

        // Three preloaded bytes sent back to back. Between frames the line
        // stays high for the IDLE sampling cycle plus FETCH and LOAD.
        en      = 1'b0;
        re0     = re_pulses;
        done0   = done_pulses;
        frames0 = frames;
        push_byte(8'h01, 1'b1);
        push_byte(8'h80, 1'b1);
        push_byte(8'hFF, 1'b0);
        repeat (8) @(negedge clk);
        check("preload_en0_re", re_pulses - re0, 0);
        en = 1'b1;
        wait_idle("burst");
        check("burst_re",     re_pulses - re0,     3);
        check("burst_done",   done_pulses - done0, 3);
        check("burst_frames", frames - frames0,    3);
        check("burst_gap",    last_gap,            3);
        check_bit("burst_fifo_empty", fifo_empty, 1'b1);

        // en=0 with five bytes waiting: nothing is fetched.
        en  = 1'b0;
        re0 = re_pulses;
        push_byte(8'h12, 1'b0);
        push_byte(8'h34, 1'b1);
        push_byte(8'h56, 1'b0);
        push_byte(8'h78, 1'b0);
        push_byte(8'h9B, 1'b1);
        repeat (20) @(negedge clk);
        check("en0_re",        re_pulses - re0, 0);
        check("en0_fifo_size", fifo_q.size(),   5);
        check_bit("en0_busy",  busy,            1'b0);

        // en dropped mid-frame: the frame completes, no further fetch.
        done0   = done_pulses;
        frames0 = frames;
        en = 1'b1;
        wait_re("midfrm");
        @(negedge clk);
        en = 1'b0;
        k = 0;
        while (busy !== 1'b0 && k < BUDGET) begin
            @(negedge clk);
            k++;
        end
        check_bit("midfrm_timeout", k < BUDGET, 1'b1);
        repeat (20) @(negedge clk);
        check("midfrm_re",        re_pulses - re0,     1);
        check("midfrm_fifo_size", fifo_q.size(),       4);
        check("midfrm_done",      done_pulses - done0, 1);
        check("midfrm_frames",    frames - frames0,    1);
        en = 1'b1;
        wait_idle("drain");
        check("drain_re",     re_pulses - re0,  5);
        check("drain_frames", frames - frames0, 5);

        // Reset during data bit 3 of 8'h3C: line high at once, no done for
        // that byte, the next byte goes out complete after release.
        re0     = re_pulses;
        done0   = done_pulses;
        frames0 = frames;
        push_byte(8'h3C, 1'b0);
        push_byte(8'h5A, 1'b0);
        k = 0;
        while (!(mon_active && mon_idx > 4 * CPB) && k < BUDGET) begin
            @(negedge clk);
            #1;
            k++;
        end
        check_bit("rst_mid_timeout", k < BUDGET, 1'b1);
        rst_n = 1'b0;
        #1;
        check_bit("rst_mid_tx",      tx,      1'b1);
        check_bit("rst_mid_busy",    busy,    1'b0);
        check_bit("rst_mid_fifo_re", fifo_re, 1'b0);
        repeat (2) @(negedge clk);
        check_bit("rst_mid_done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_idle("post_rst");
        check("post_rst_re",     re_pulses - re0,     2);
        check("post_rst_done",   done_pulses - done0, 1);
        check("post_rst_frames", frames - frames0,    1);
        check("post_rst_expq",   exp_q.size(),        0);

        check("re_on_empty", re_on_empty, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, tests run %0d", n_tests);
        $fatal(1, "watchdog expired");
    end

endmodule
